// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg
// Shared definitions for the SPI memory master: command opcodes, the FSM
// state type and a helper that gives the number of SCK bits in one frame.
// Optional feature macro: SPI_FAST_READ_EN (reads use 0x0B plus 8 dummy clocks).
package spi_mem_pkg;

   localparam logic [7:0] CMD_READ      = 8'h03;
   localparam logic [7:0] CMD_WRITE     = 8'h02;
   localparam logic [7:0] CMD_FAST_READ = 8'h0B;

`ifdef SPI_FAST_READ_EN
   localparam bit FAST_READ_EN = 1'b1;
`else
   localparam bit FAST_READ_EN = 1'b0;
`endif

   localparam logic [7:0] READ_OPCODE = FAST_READ_EN ? CMD_FAST_READ : CMD_READ;
   localparam int         DUMMY_BITS  = FAST_READ_EN ? 8 : 0;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
`ifdef SPI_FAST_READ_EN
      DUMMY,
`endif
      DATA,
      DONE
   } state_t;

   // Total SCK bits for one transaction; the dummy byte only exists on reads.
   function automatic int frame_bits(input int addr_w, input int data_bytes, input bit is_read);
      return 8 + addr_w + 8 * data_bytes + (is_read ? DUMMY_BITS : 0);
   endfunction

endpackage

// File: rtl/spi_mem_master_clk_gen.sv
// spi_clk_gen
// Divides clk down to the SPI serial clock. Each SCK phase lasts DIV clk
// cycles. rise_stb/fall_stb are high for the one clk cycle whose closing edge
// moves spi_sck high/low, so the master can shift on exactly that edge.
// Ports: clk, rst (async, active-high), en (transaction active),
//        spi_sck (registered, idles low), rise_stb, fall_stb.
module spi_clk_gen #(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic spi_sck,
   output logic rise_stb,
   output logic fall_stb
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CNT_W-1:0] cnt;
   logic             tick;

   assign tick     = en && (cnt == CNT_W'(DIV - 1));
   assign rise_stb = tick && !spi_sck;
   assign fall_stb = tick &&  spi_sck;

   // Phase counter: restarts whenever the bus is idle so the first SCK rise
   // always comes exactly DIV cycles after chip select falls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         spi_sck <= 1'b0;
      end else if (!en) begin
         cnt     <= '0;
         spi_sck <= 1'b0;
      end else if (tick) begin
         cnt     <= '0;
         spi_sck <= ~spi_sck;
      end else begin
         cnt     <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/spi_mem_master.sv
// spi_mem_master
// SPI mode-0 memory master: turns a single valid/ready read or write request
// into an opcode / address / data frame against an external SPI RAM and
// reports completion with a one-cycle rsp_valid pulse.
// Optional feature macro: SPI_FAST_READ_EN (0x0B reads with 8 dummy clocks).
// Ports: clk, rst (async, active-high); request side req_valid/req_ready,
//        req_we, req_addr, req_wdata; response rsp_valid, rsp_rdata; busy;
//        SPI pins spi_cs_n, spi_sck, spi_mosi, spi_miso. All outputs registered.
module spi_mem_master
   import spi_mem_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int DATA_BYTES = 1,
   parameter int DIV        = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [ADDR_W-1:0]       req_addr,
   input  logic [8*DATA_BYTES-1:0] req_wdata,
   output logic                    rsp_valid,
   output logic [8*DATA_BYTES-1:0] rsp_rdata,
   output logic                    busy,
   output logic                    spi_cs_n,
   output logic                    spi_sck,
   output logic                    spi_mosi,
   input  logic                    spi_miso
);

   localparam int DATA_W   = 8 * DATA_BYTES;
   localparam int SHIFT_W  = 8 + ADDR_W + DATA_W;
   localparam int CMD_END  = 7;
   localparam int ADDR_END = CMD_END + ADDR_W;
   localparam int LAST_WR  = frame_bits(ADDR_W, DATA_BYTES, 1'b0) - 1;
   localparam int LAST_RD  = frame_bits(ADDR_W, DATA_BYTES, 1'b1) - 1;
`ifdef SPI_FAST_READ_EN
   localparam int DUMMY_END = ADDR_END + DUMMY_BITS;
`endif

   state_t              state;
   logic                we;
   logic [6:0]          bit_idx;
   logic [SHIFT_W-1:0]  tx_shift;
   logic [DATA_W-1:0]   rx_shift;
   logic [DATA_W-1:0]   wdata_swap;
   logic [DATA_W-1:0]   rdata_swap;
   logic                rise_stb;
   logic                fall_stb;

   spi_clk_gen #(.DIV(DIV)) u_clk_gen (
      .clk      (clk),
      .rst      (rst),
      .en       (!spi_cs_n),
      .spi_sck  (spi_sck),
      .rise_stb (rise_stb),
      .fall_stb (fall_stb)
   );

   // The wire carries byte 0 first, but the bus keeps byte 0 in the low bits,
   // so both directions need a byte-order reversal.
   always_comb begin
      wdata_swap = '0;
      rdata_swap = '0;
      for (int i = 0; i < DATA_BYTES; i++) begin
         wdata_swap[8*(DATA_BYTES-1-i) +: 8] = req_wdata[8*i +: 8];
         rdata_swap[8*i +: 8]                = rx_shift[8*(DATA_BYTES-1-i) +: 8];
      end
   end

   // Main sequencer. bit_idx counts frame bits from the opcode MSB; phase
   // changes happen on the falling-edge strobe, which is also where MOSI moves
   // so it is always stable across the following rising edge. tx_shift MSB is
   // kept equal to the bit currently on MOSI (except during dummy clocks).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         we        <= 1'b0;
         bit_idx   <= '0;
         tx_shift  <= '0;
         rx_shift  <= '0;
         req_ready <= 1'b1;
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         spi_cs_n  <= 1'b1;
         spi_mosi  <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  we        <= req_we;
                  bit_idx   <= '0;
                  tx_shift  <= {(req_we ? CMD_WRITE : READ_OPCODE), req_addr,
                                (req_we ? wdata_swap : {DATA_W{1'b0}})};
                  spi_mosi  <= req_we ? CMD_WRITE[7] : READ_OPCODE[7];
                  spi_cs_n  <= 1'b0;
                  busy      <= 1'b1;
                  req_ready <= 1'b0;
                  state     <= CMD;
               end
            end
            DONE: begin
               busy      <= 1'b0;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               if (rise_stb && state == DATA && !we) begin
                  rx_shift <= {rx_shift[DATA_W-2:0], spi_miso};
               end
               if (fall_stb) begin
                  bit_idx <= bit_idx + 7'd1;
                  case (state)
                     CMD: begin
                        tx_shift <= tx_shift << 1;
                        spi_mosi <= tx_shift[SHIFT_W-2];
                        if (bit_idx == 7'(CMD_END)) begin
                           state <= ADDR;
                        end
                     end
                     ADDR: begin
                        tx_shift <= tx_shift << 1;
                        spi_mosi <= tx_shift[SHIFT_W-2];
                        if (bit_idx == 7'(ADDR_END)) begin
`ifdef SPI_FAST_READ_EN
                           if (!we) begin
                              spi_mosi <= 1'b0;
                              state    <= DUMMY;
                           end else begin
                              state    <= DATA;
                           end
`else
                           state <= DATA;
`endif
                        end
                     end
`ifdef SPI_FAST_READ_EN
                     DUMMY: begin
                        if (bit_idx == 7'(DUMMY_END)) begin
                           spi_mosi <= tx_shift[SHIFT_W-1];
                           state    <= DATA;
                        end
                     end
`endif
                     DATA: begin
                        if (bit_idx == (we ? 7'(LAST_WR) : 7'(LAST_RD))) begin
                           spi_cs_n  <= 1'b1;
                           spi_mosi  <= 1'b0;
                           rsp_valid <= 1'b1;
                           if (!we) begin
                              rsp_rdata <= rdata_swap;
                           end
                           state     <= DONE;
                        end else begin
                           tx_shift <= tx_shift << 1;
                           spi_mosi <= tx_shift[SHIFT_W-2];
                        end
                     end
                     default: begin
                        state <= IDLE;
                     end
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_mem_master.sv
// tb_spi_mem_master
// Three instances: dut 0 default (ADDR_W=16, DATA_BYTES=1, DIV=1), dut 1 with
// DATA_BYTES=2, dut 2 with ADDR_W=24, DIV=3. A per-instance SPI slave model
// captures MOSI on rising SCK and serves MISO after each falling SCK.
// Follows SPI_FAST_READ_EN when it is defined for the build.
module tb_spi_mem_master;

`ifdef SPI_FAST_READ_EN
   localparam logic [7:0] RD_OP    = 8'h0B;
   localparam int         RD_EXTRA = 8;
`else
   localparam logic [7:0] RD_OP    = 8'h03;
   localparam int         RD_EXTRA = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int testsRun    = 0;
   int testsFailed = 0;

   logic [2:0] reqValid = '0;
   logic [2:0] reqWe    = '0;
   logic [2:0] reqReady, rspValid, busy, csN, sck, mosi;
   logic [2:0] miso = '0;
   logic [15:0] addr0 = '0, addr1 = '0;
   logic [23:0] addr2 = '0;
   logic [7:0]  wdata0 = '0, wdata2 = '0;
   logic [15:0] wdata1 = '0;
   logic [7:0]  rdata0, rdata2;
   logic [15:0] rdata1;

   spi_mem_master #(.ADDR_W(16), .DATA_BYTES(1), .DIV(1)) dut0 (
      .clk(clk), .rst(rst), .req_valid(reqValid[0]), .req_ready(reqReady[0]),
      .req_we(reqWe[0]), .req_addr(addr0), .req_wdata(wdata0),
      .rsp_valid(rspValid[0]), .rsp_rdata(rdata0), .busy(busy[0]),
      .spi_cs_n(csN[0]), .spi_sck(sck[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0]));

   spi_mem_master #(.ADDR_W(16), .DATA_BYTES(2), .DIV(1)) dut1 (
      .clk(clk), .rst(rst), .req_valid(reqValid[1]), .req_ready(reqReady[1]),
      .req_we(reqWe[1]), .req_addr(addr1), .req_wdata(wdata1),
      .rsp_valid(rspValid[1]), .rsp_rdata(rdata1), .busy(busy[1]),
      .spi_cs_n(csN[1]), .spi_sck(sck[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1]));

   spi_mem_master #(.ADDR_W(24), .DATA_BYTES(1), .DIV(3)) dut2 (
      .clk(clk), .rst(rst), .req_valid(reqValid[2]), .req_ready(reqReady[2]),
      .req_we(reqWe[2]), .req_addr(addr2), .req_wdata(wdata2),
      .rsp_valid(rspValid[2]), .rsp_rdata(rdata2), .busy(busy[2]),
      .spi_cs_n(csN[2]), .spi_sck(sck[2]), .spi_mosi(mosi[2]), .spi_miso(miso[2]));

   // Slave model and bus monitor state, one slot per instance.
   logic [63:0] misoFrame [3];
   logic [63:0] mosiCap   [3];
   int riseCnt[3], misoIdx[3], rspCnt[3], csHiRun[3], csGap[3];
   int sckRun[3], hiMin[3], hiMax[3], loMin[3], loMax[3];
   logic [2:0] prevCs = '1, prevSck = '0, prevMosi = '0;
   int mosiGlitch = 0;

   // Sampled on the falling clk edge, away from the DUT's active edge.
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (rst) begin
            prevCs[d]   = 1'b1;
            prevSck[d]  = 1'b0;
            prevMosi[d] = 1'b0;
            miso[d]     = 1'b0;
            csHiRun[d]  = 0;
         end else begin
            if (rspValid[d]) rspCnt[d]++;
            if (!csN[d]) begin
               if (prevCs[d]) begin
                  csGap[d]   = csHiRun[d];
                  csHiRun[d] = 0;
                  riseCnt[d] = 0;
                  mosiCap[d] = '0;
                  misoIdx[d] = 0;
                  miso[d]    = misoFrame[d][63];
                  sckRun[d]  = 1;
                  hiMin[d] = 1000; hiMax[d] = 0; loMin[d] = 1000; loMax[d] = 0;
               end else begin
                  if (sck[d] == prevSck[d]) begin
                     sckRun[d]++;
                  end else begin
                     if (prevSck[d]) begin
                        if (sckRun[d] < hiMin[d]) hiMin[d] = sckRun[d];
                        if (sckRun[d] > hiMax[d]) hiMax[d] = sckRun[d];
                     end else begin
                        if (sckRun[d] < loMin[d]) loMin[d] = sckRun[d];
                        if (sckRun[d] > loMax[d]) loMax[d] = sckRun[d];
                     end
                     sckRun[d] = 1;
                  end
                  if (sck[d] && !prevSck[d]) begin
                     mosiCap[d] = {mosiCap[d][62:0], mosi[d]};
                     riseCnt[d]++;
                     if (mosi[d] !== prevMosi[d]) mosiGlitch++;
                  end
                  if (sck[d] && prevSck[d] && mosi[d] !== prevMosi[d]) mosiGlitch++;
                  if (!sck[d] && prevSck[d]) begin
                     misoIdx[d]++;
                     if (misoIdx[d] < 64) miso[d] = misoFrame[d][63 - misoIdx[d]];
                  end
               end
            end else begin
               csHiRun[d]++;
            end
            prevCs[d]   = csN[d];
            prevSck[d]  = sck[d];
            prevMosi[d] = mosi[d];
         end
      end
   end

   // Serial MISO stream: pre bits of 1s, then nbits of data, then 1s.
   function automatic logic [63:0] makeMiso(input int pre, input logic [31:0] data, input int nbits);
      logic [63:0] f;
      f = '1;
      for (int i = 0; i < nbits; i++) f[63 - pre - i] = data[nbits - 1 - i];
      return f;
   endfunction

   function automatic logic [15:0] rdataOf(input int d);
      case (d)
         0:       return {8'h00, rdata0};
         1:       return rdata1;
         default: return {8'h00, rdata2};
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // One request on instance d; returns cycles from accept to rsp_valid.
   task automatic applyStimulus(input int d, input logic we, input logic [23:0] addr,
                                input logic [15:0] wdata, input logic [63:0] frame,
                                output int latency);
      int base;
      @(negedge clk);
      misoFrame[d] = frame;
      case (d)
         0:       begin addr0 = addr[15:0]; wdata0 = wdata[7:0]; end
         1:       begin addr1 = addr[15:0]; wdata1 = wdata; end
         default: begin addr2 = addr; wdata2 = wdata[7:0]; end
      endcase
      reqWe[d]    = we;
      reqValid[d] = 1'b1;
      @(negedge clk);
      reqValid[d] = 1'b0;
      base = rspCnt[d];
      checkOutput($sformatf("d%0d_cs_low_t1", d), csN[d], 1'b0);
      checkOutput($sformatf("d%0d_busy_t1", d), busy[d], 1'b1);
      latency = 1;
      while (!rspValid[d] && latency < 2000) begin
         @(negedge clk);
         latency++;
      end
      checkOutput($sformatf("d%0d_rsp_seen", d), rspValid[d], 1'b1);
      checkOutput($sformatf("d%0d_cs_high_done", d), csN[d], 1'b1);
      @(negedge clk);
      checkOutput($sformatf("d%0d_rsp_one_pulse", d), rspCnt[d] - base, 1);
      checkOutput($sformatf("d%0d_ready_after", d), reqReady[d], 1'b1);
   endtask

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [63:0] frame;
      logic [63:0] expMosi;
      int          expBits;
      logic [7:0]  expRdata;
      int          expLat;
   } vec_t;

   localparam int N0RD = 32 + RD_EXTRA;
   vec_t vecs[5];

   initial begin
      int lat, base, cnt;

      vecs[0] = '{1'b0, 16'h1234, 8'h00, makeMiso(24 + RD_EXTRA, 32'hA5, 8),
                  64'({RD_OP, 16'h1234, 8'h00}) << RD_EXTRA, N0RD, 8'hA5, 1 + 2 * N0RD};
      vecs[1] = '{1'b1, 16'h0042, 8'h3C, '1,
                  64'({8'h02, 16'h0042, 8'h3C}), 32, 8'hA5, 65};
      vecs[2] = '{1'b0, 16'hFFFF, 8'h00, makeMiso(24 + RD_EXTRA, 32'h00, 8),
                  64'({RD_OP, 16'hFFFF, 8'h00}) << RD_EXTRA, N0RD, 8'h00, 1 + 2 * N0RD};
      vecs[3] = '{1'b0, 16'h0000, 8'h00, makeMiso(24 + RD_EXTRA, 32'hFF, 8),
                  64'({RD_OP, 16'h0000, 8'h00}) << RD_EXTRA, N0RD, 8'hFF, 1 + 2 * N0RD};
      vecs[4] = '{1'b1, 16'hFFFF, 8'h81, '1,
                  64'({8'h02, 16'hFFFF, 8'h81}), 32, 8'hFF, 65};
      for (int d = 0; d < 3; d++) misoFrame[d] = '1;

      // Reset values
      #2 rst = 1'b1;
      @(negedge clk); @(negedge clk);
      checkOutput("rst_cs_n", csN[0], 1'b1);
      checkOutput("rst_sck", sck[0], 1'b0);
      checkOutput("rst_mosi", mosi[0], 1'b0);
      checkOutput("rst_rsp_valid", rspValid[0], 1'b0);
      checkOutput("rst_busy", busy[0], 1'b0);
      checkOutput("rst_rdata1", rdata1, 16'h0000);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_ready0", reqReady[0], 1'b1);

      // Table-driven transactions on the default instance
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, vecs[i].we, {8'h00, vecs[i].addr}, {8'h00, vecs[i].wdata}, vecs[i].frame, lat);
         checkOutput($sformatf("v%0d_latency", i), lat, vecs[i].expLat);
         checkOutput($sformatf("v%0d_mosi", i), mosiCap[0], vecs[i].expMosi);
         checkOutput($sformatf("v%0d_bits", i), riseCnt[0], vecs[i].expBits);
         checkOutput($sformatf("v%0d_rdata", i), rdataOf(0), {8'h00, vecs[i].expRdata});
      end

      // Two-byte instance: read then write, write leaves rdata alone
      applyStimulus(1, 1'b0, 24'h000100, 16'h0000, makeMiso(24 + RD_EXTRA, 32'h3C5A, 16), lat);
      checkOutput("d1rd_latency", lat, 1 + 2 * (40 + RD_EXTRA));
      checkOutput("d1rd_mosi", mosiCap[1], 64'({RD_OP, 16'h0100, 16'h0000}) << RD_EXTRA);
      checkOutput("d1rd_rdata", rdataOf(1), 16'h5A3C);
      applyStimulus(1, 1'b1, 24'h0000FF, 16'hBEEF, '1, lat);
      checkOutput("d1wr_latency", lat, 81);
      checkOutput("d1wr_mosi", mosiCap[1], 64'({8'h02, 16'h00FF, 8'hEF, 8'hBE}));
      checkOutput("d1wr_bits", riseCnt[1], 40);
      checkOutput("d1wr_rdata_kept", rdataOf(1), 16'h5A3C);

      // Slow SCK, 24-bit address
      applyStimulus(2, 1'b0, 24'hABCDEF, 16'h0000, makeMiso(32 + RD_EXTRA, 32'h96, 8), lat);
      checkOutput("d2_latency", lat, 1 + 6 * (40 + RD_EXTRA));
      checkOutput("d2_rises", riseCnt[2], 40 + RD_EXTRA);
      checkOutput("d2_mosi", mosiCap[2], 64'({RD_OP, 24'hABCDEF, 8'h00}) << RD_EXTRA);
      checkOutput("d2_rdata", rdataOf(2), 16'h0096);
      checkOutput("d2_hi_min", hiMin[2], 3);
      checkOutput("d2_hi_max", hiMax[2], 3);
      checkOutput("d2_lo_min", loMin[2], 3);
      checkOutput("d2_lo_max", loMax[2], 3);

      // Back-to-back reads with req_valid held high
      applyStimulus(0, 1'b0, 24'h000010, 16'h0000, makeMiso(24 + RD_EXTRA, 32'h6B, 8), lat);
      @(negedge clk);
      base = rspCnt[0];
      reqValid[0] = 1'b1;
      cnt = 0;
      while (!rspValid[0] && cnt < 2000) begin @(negedge clk); cnt++; end
      checkOutput("b2b_first_rsp", rspValid[0], 1'b1);
      cnt = 0;
      @(negedge clk); cnt++;
      checkOutput("b2b_ready_after_done", reqReady[0], 1'b1);
      @(negedge clk); cnt++;
      reqValid[0] = 1'b0;
      while (!rspValid[0] && cnt < 2000) begin @(negedge clk); cnt++; end
      checkOutput("b2b_rsp_spacing", cnt, 2 + 2 * N0RD);
      checkOutput("b2b_cs_gap", csGap[0], 2);
      checkOutput("b2b_rdata", rdataOf(0), 16'h006B);
      repeat (100) @(negedge clk);
      checkOutput("b2b_rsp_count", rspCnt[0] - base, 2);

      // Reset in the middle of the address phase
      @(negedge clk);
      misoFrame[0] = makeMiso(24 + RD_EXTRA, 32'h11, 8);
      addr0 = 16'h2222; reqWe[0] = 1'b0; reqValid[0] = 1'b1;
      @(negedge clk);
      reqValid[0] = 1'b0;
      repeat (19) @(negedge clk);
      checkOutput("mid_in_transfer", csN[0], 1'b0);
      base = rspCnt[0];
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_cs_n", csN[0], 1'b1);
      checkOutput("mid_rst_sck", sck[0], 1'b0);
      checkOutput("mid_rst_busy", busy[0], 1'b0);
      checkOutput("mid_rst_mosi", mosi[0], 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("mid_rst_rdata", rdataOf(0), 16'h0000);
      checkOutput("mid_rst_ready", reqReady[0], 1'b1);
      repeat (100) @(negedge clk);
      checkOutput("mid_rst_no_rsp", rspCnt[0] - base, 0);
      applyStimulus(0, 1'b0, 24'h004321, 16'h0000, makeMiso(24 + RD_EXTRA, 32'h5C, 8), lat);
      checkOutput("post_rst_latency", lat, 1 + 2 * N0RD);
      checkOutput("post_rst_mosi", mosiCap[0], 64'({RD_OP, 16'h4321, 8'h00}) << RD_EXTRA);
      checkOutput("post_rst_rdata", rdataOf(0), 16'h005C);

      checkOutput("mosi_stable_while_sck_high", mosiGlitch, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
